// File: rtl/interp_pkg.sv
// Shared types and select tables for the interpolation sequencer.
// ROUND state exists only when INTERP_ROUND_EN is defined.
// The tables are indexed by subcarrier, 0..N_SC-1.
package interp_pkg;

    localparam int N_SC  = 12;
    localparam int IDX_W = 4;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef INTERP_ROUND_EN
        S_ROUND,
`endif
        S_FIN,
        S_DONE
    } state_t;

    // Operand-B mux codes; B_ZERO is the mux's idle default.
    localparam sel_t B_E3   = 3'b000;
    localparam sel_t B_2E3  = 3'b001;
    localparam sel_t B_REGE = 3'b010;
    localparam sel_t B_E4   = 3'b011;
    localparam sel_t B_4E1  = 3'b100;
    localparam sel_t B_ONE  = 3'b110;
    localparam sel_t B_ZERO = 3'b111;

    // Operand-A mux codes.
    localparam sel_t A_E1   = 3'b000;
    localparam sel_t A_E3   = 3'b001;
    localparam sel_t A_E4   = 3'b010;
    localparam sel_t A_REG  = 3'b011;
    localparam sel_t A_ZERO = 3'b111;

    localparam sel_t SEL_A_LUT [N_SC] = '{
        A_E1, A_E1, A_E1, A_E3, A_E3, A_E3,
        A_E3, A_E3, A_E4, A_E4, A_E4, A_E4
    };

    localparam sel_t SEL_B_LUT [N_SC] = '{
        B_4E1, B_E3,  B_2E3, B_E3, B_E4, B_2E3,
        B_E4,  B_E3,  B_E4,  B_2E3, B_E4, B_4E1
    };

    // Final add: even subcarriers fold in reg_E again, odd ones pass through.
    localparam sel_t FIN_B_LUT [N_SC] = '{
        B_REGE, B_ZERO, B_REGE, B_ZERO, B_REGE, B_ZERO,
        B_REGE, B_ZERO, B_REGE, B_ZERO, B_REGE, B_ZERO
    };

endpackage

// File: rtl/interp_sel_rom.sv
// Per-subcarrier select lookup for the LOAD and FIN steps.
// Latency: combinational. Backpressure: none (pure decode).
// Out-of-range indices return the zero/idle codes.
module interp_sel_rom
    import interp_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [SEL_W-1:0] load_a,
    output logic [SEL_W-1:0] load_b,
    output logic [SEL_W-1:0] fin_b
);

    always_comb begin
        load_a = A_ZERO;
        load_b = B_ZERO;
        fin_b  = B_ZERO;
        if (idx < IDX_W'(N_SC)) begin
            load_a = SEL_A_LUT[idx];
            load_b = SEL_B_LUT[idx];
            fin_b  = FIN_B_LUT[idx];
        end
    end

endmodule

// File: rtl/interp_seq_ctrl.sv
// Walks 12 subcarriers driving adder operand selects and reg_E load; INTERP_ROUND_EN adds a ROUND step.
// Latency: start -> first LOAD 1 cycle; 3 (ROUND) or 2 cycles per subcarrier without stall.
// Backpressure: FIN holds all outputs while out_ready is low; out_ready reaches outputs only via registers.
module interp_seq_ctrl
    import interp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b,
    output logic             reg_en,
    output logic             out_valid,
    output logic [IDX_W-1:0] sc_idx,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [SEL_W-1:0] rom_a;
    logic [SEL_W-1:0] rom_b;
    logic [SEL_W-1:0] rom_fin_b;

    interp_sel_rom u_rom (
        .idx    (sc_idx),
        .load_a (rom_a),
        .load_b (rom_b),
        .fin_b  (rom_fin_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sc_idx    <= '0;
            busy      <= 1'b0;
            reg_en    <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state     <= S_IDLE;
                sc_idx    <= '0;
                busy      <= 1'b0;
                reg_en    <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state  <= S_LOAD;
                            sc_idx <= '0;
                            busy   <= 1'b1;
                            reg_en <= 1'b1;
                        end
                    end
                    S_LOAD: begin
`ifdef INTERP_ROUND_EN
                        state     <= S_ROUND;
`else
                        state     <= S_FIN;
                        reg_en    <= 1'b0;
                        out_valid <= 1'b1;
`endif
                    end
`ifdef INTERP_ROUND_EN
                    S_ROUND: begin
                        state     <= S_FIN;
                        reg_en    <= 1'b0;
                        out_valid <= 1'b1;
                    end
`endif
                    S_FIN: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (sc_idx == IDX_W'(N_SC - 1)) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state  <= S_LOAD;
                                sc_idx <= sc_idx + 1'b1;
                                reg_en <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        sc_idx <= '0;
                    end
                    default: begin
                        state     <= S_IDLE;
                        sc_idx    <= '0;
                        busy      <= 1'b0;
                        reg_en    <= 1'b0;
                        out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Selects are a pure decode of state and sc_idx, so reset clears them immediately.
    always_comb begin
        sel_a = A_ZERO;
        sel_b = B_ZERO;
        case (state)
            S_LOAD: begin
                sel_a = rom_a;
                sel_b = rom_b;
            end
`ifdef INTERP_ROUND_EN
            S_ROUND: begin
                sel_a = A_REG;
                sel_b = B_ONE;
            end
`endif
            S_FIN: begin
                sel_a = A_REG;
                sel_b = rom_fin_b;
            end
            default: begin
                sel_a = A_ZERO;
                sel_b = B_ZERO;
            end
        endcase
    end

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Directed bench for interp_seq_ctrl; expected timing follows INTERP_ROUND_EN.
module tb_interp_seq_ctrl;

`ifdef INTERP_ROUND_EN
    localparam int PER = 3;
`else
    localparam int PER = 2;
`endif
    localparam int NSC = 12;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       flush;
    logic       out_ready;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic       reg_en;
    logic       out_valid;
    logic [3:0] sc_idx;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    logic [2:0] ea [NSC];
    logic [2:0] eb [NSC];
    logic [2:0] ef [NSC];

    logic [13:0] idle_v;

    interp_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .out_ready (out_ready),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .reg_en    (reg_en),
        .out_valid (out_valid),
        .sc_idx    (sc_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] vec(input logic [2:0] a, input logic [2:0] b,
                                        input logic re, input logic ov,
                                        input logic [3:0] ix, input logic bz, input logic dn);
        return {a, b, re, ov, ix, bz, dn};
    endfunction

    function automatic logic [13:0] got();
        return {sel_a, sel_b, reg_en, out_valid, sc_idx, busy, done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run from start: stall_k/stall_n hold FIN at that index, the *_at
    // arguments (cycle positions, -1 = off) inject flush+start, reset or a stray start.
    task automatic run(input int stall_k, input int stall_n, input int flush_at,
                       input int rst_at, input int start_at);
        logic [13:0] ev[$];
        bit          rq[$];
        int          done_cyc;
        done_cyc = -1;
        for (int k = 0; k < NSC; k++) begin
            ev.push_back(vec(ea[k], eb[k], 1'b1, 1'b0, 4'(k), 1'b1, 1'b0));
            rq.push_back(1'b1);
            if (PER == 3) begin
                ev.push_back(vec(3'b011, 3'b110, 1'b1, 1'b0, 4'(k), 1'b1, 1'b0));
                rq.push_back(1'b1);
            end
            for (int j = 0; j <= ((k == stall_k) ? stall_n : 0); j++) begin
                ev.push_back(vec(3'b011, ef[k], 1'b0, 1'b1, 4'(k), 1'b1, 1'b0));
                rq.push_back(!(k == stall_k && j < stall_n));
            end
        end
        ev.push_back(vec(3'b111, 3'b111, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1));
        rq.push_back(1'b1);
        ev.push_back(idle_v);
        rq.push_back(1'b1);

        @(posedge clk); #1;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < ev.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            start = 1'b0;
            flush = 1'b0;
            chk($sformatf("seq[%0d]", i), 32'(got()), 32'(ev[i]));
            if (done === 1'b1) done_cyc = i + 1;
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("reset_mid_run", 32'(got()), 32'(idle_v));
                #2;
                rst_n = 1'b1;
                @(posedge clk); #1;
                chk("after_reset", 32'(got()), 32'(idle_v));
                return;
            end
            if (i == flush_at) begin
                flush = 1'b1;
                start = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                start = 1'b0;
                chk("flush_idle", 32'(got()), 32'(idle_v));
                for (int j = 0; j < 4; j++) begin
                    @(posedge clk); #1;
                    chk($sformatf("flush_nodone[%0d]", j), 32'(got()), 32'(idle_v));
                end
                return;
            end
            if (i == start_at) start = 1'b1;
            out_ready = rq[i];
        end
        chk("done_cycle", 32'(done_cyc), 32'(1 + PER * NSC + stall_n));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        ea = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001,
               3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010};
        eb = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b011, 3'b001,
               3'b011, 3'b000, 3'b011, 3'b001, 3'b011, 3'b100};
        ef = '{3'b010, 3'b111, 3'b010, 3'b111, 3'b010, 3'b111,
               3'b010, 3'b111, 3'b010, 3'b111, 3'b010, 3'b111};
        idle_v = vec(3'b111, 3'b111, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        #3;
        chk("reset_state", 32'(got()), 32'(idle_v));
        @(posedge clk); #1;
        chk("reset_sel_b", 32'(sel_b), 32'(3'b111));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_release", 32'(got()), 32'(idle_v));

        run(-1, 0, -1, -1, -1);
        run(3, 4, -1, -1, -1);
        run(-1, 0, -1, -1, 4);
        run(-1, 0, 7 * PER, -1, -1);
        run(-1, 0, -1, -1, -1);
        run(-1, 0, -1, 5 * PER + PER - 1, -1);
        run(-1, 0, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
